// File: rtl/psum_collector.sv
// ---------------------------------------------------------------------------
// psum_collector
//   Collects the partial-sum stream leaving the bottom PE of a systolic column.
//   DEPTH consecutive partial sums form one tile row; the same DEPTH addresses
//   are revisited once per input-channel tiling pass and accumulated locally.
//   When the last pass completes, the finished sums are drained in address
//   order over a valid/ready handshake. The column cannot be stalled, so any
//   sample arriving outside ACCUM is discarded and flagged in drop_err.
//
// Optional feature (macro PSUM_COLLECTOR_SAT_EN):
//   defined   -> signed saturating accumulation
//   undefined -> modulo 2^accumulationPar wrap-around addition
//
// Handshake: out_data is transferred on a rising edge where out_valid and
//   out_ready are both high. While out_valid is high and out_ready is low,
//   out_data and the read pointer hold. psum_valid has no backpressure.
//
// Ports:
//   clk, rst     clock (rising edge), async active-high reset
//   start        begin a tile (IDLE only); num_passes sampled at that edge
//   num_passes   accumulation passes, 0 behaves as 1
//   psum_in      partial sum from the last PE, qualified by psum_valid
//   out_data     finished sum at the drain pointer
//   out_valid    out_data valid (DRAIN state)
//   out_ready    downstream accepts out_data
//   busy         high in ACCUM or DRAIN
//   drop_err     sticky, a psum_valid sample was discarded
//   stateDbg     current FSM state (0 IDLE, 1 ACCUM, 2 DRAIN)
// ---------------------------------------------------------------------------
module psum_collector #(
  parameter int accumulationPar = 32,
  parameter int DEPTH           = 8,
  parameter int PASS_W          = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [PASS_W-1:0]          num_passes,
  input  logic [accumulationPar-1:0] psum_in,
  input  logic                       psum_valid,
  output logic [accumulationPar-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       drop_err,
  output logic [1:0]                 stateDbg
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, DRAIN = 2'd2} state_t;

  state_t                     state;
  logic [AW-1:0]              wrAddr;
  logic [AW-1:0]              rdAddr;
  logic [PASS_W-1:0]          passCnt;
  logic [PASS_W-1:0]          lastPass;
  logic [accumulationPar-1:0] mem [DEPTH];
  logic [accumulationPar-1:0] accNext;

  wire accept  = (state == IDLE) && start;
  wire wrEn    = (state == ACCUM) && psum_valid;
  // Any sample outside ACCUM is lost, including the cycle start is accepted.
  wire dropNow = psum_valid && (state != ACCUM);

  // Sum of the stored partial and the incoming sample.
`ifdef PSUM_COLLECTOR_SAT_EN
  logic [accumulationPar-1:0] rawSum;
  logic                       ovf;
  always_comb begin
    rawSum  = mem[wrAddr] + psum_in;
    // Overflow only when both operands share a sign the result does not.
    ovf     = (mem[wrAddr][accumulationPar-1] == psum_in[accumulationPar-1]) &&
              (rawSum[accumulationPar-1] != psum_in[accumulationPar-1]);
    accNext = rawSum;
    if (ovf) begin
      accNext = psum_in[accumulationPar-1] ?
                {1'b1, {(accumulationPar-1){1'b0}}} :
                {1'b0, {(accumulationPar-1){1'b1}}};
    end
  end
`else
  always_comb begin
    accNext = mem[wrAddr] + psum_in;
  end
`endif

  // Buffer is intentionally not reset; pass 0 overwrites every address, so a
  // fresh tile never sees stale contents.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= (passCnt == '0) ? psum_in : accNext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wrAddr   <= '0;
      rdAddr   <= '0;
      passCnt  <= '0;
      lastPass <= '0;
      drop_err <= 1'b0;
    end else begin
      // Set has priority over the clear performed by an accepted start.
      if (dropNow)     drop_err <= 1'b1;
      else if (accept) drop_err <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            lastPass <= (num_passes == '0) ? '0 : num_passes - PASS_W'(1);
            wrAddr   <= '0;
            rdAddr   <= '0;
            passCnt  <= '0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (psum_valid) begin
            if (wrAddr == LAST_ADDR) begin
              wrAddr <= '0;
              if (passCnt == lastPass) begin
                state  <= DRAIN;
                rdAddr <= '0;
              end else begin
                passCnt <= passCnt + PASS_W'(1);
              end
            end else begin
              wrAddr <= wrAddr + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rdAddr == LAST_ADDR) begin
              rdAddr <= '0;
              state  <= IDLE;
            end else begin
              rdAddr <= rdAddr + AW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode directly from registers; out_data reads the array
  // combinationally so the final write is visible in the first DRAIN cycle.
  assign out_valid = (state == DRAIN);
  assign busy      = (state != IDLE);
  assign out_data  = mem[rdAddr];
  assign stateDbg  = state;

endmodule

// File: tb/tb_psum_collector.sv
// ---------------------------------------------------------------------------
// tb_psum_collector
//   Directed-vector bench for psum_collector. Expected drained sums are
//   hand-computed and pushed to exp_q as each tile's final pass is issued; an
//   independent monitor pops and compares on every handshake transfer.
// ---------------------------------------------------------------------------
module tb_psum_collector;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    num_passes;
  logic [W-1:0]  psum_in;
  logic          psum_valid;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          drop_err;
  logic [1:0]    state_dbg;

  int n_vec  = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] pv[8];

  psum_collector #(.accumulationPar(W), .DEPTH(8), .PASS_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_passes(num_passes),
    .psum_in(psum_in), .psum_valid(psum_valid), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .drop_err(drop_err), .stateDbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: inputs change 1 time unit after posedge, so at negedge the
  // handshake state is what the next rising edge will sample.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_out: got 0x%08h, expected no transfer", out_data);
      end else begin
        check("drain_data", out_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input logic [7:0] np, input logic drop_it);
    start      = 1'b1;
    num_passes = np;
    psum_valid = drop_it;
    psum_in    = 32'hDEAD_BEEF;
    step();
    start      = 1'b0;
    psum_valid = 1'b0;
  endtask

  // Send pv[0..7]; random 1..gap_max idle cycles between samples when gap_max>0.
  task automatic feed_pass(input int gap_max);
    for (int i = 0; i < 8; i++) begin
      psum_valid = 1'b1;
      psum_in    = pv[i];
      step();
      psum_valid = 1'b0;
      if (gap_max > 0 && i < 7) repeat ($urandom_range(1, gap_max)) step();
    end
  endtask

  task automatic fill_const(input logic [W-1:0] v);
    for (int i = 0; i < 8; i++) pv[i] = v;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 200) begin
      step();
      cycles++;
    end
    check("drain_timeout_busy", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  int cyc;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num_passes = '0;
    psum_in    = '0;
    psum_valid = 1'b0;
    out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    check("rst_drop_err",  {31'd0, drop_err},  32'd0);
    check("rst_state",     {30'd0, state_dbg}, 32'd0);
    rst = 1'b0;
    step();

    // 1) single pass 1..8, back to back, out_ready held high
    start_tile(8'd1, 1'b0);
    check("t1_busy_accum", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      pv[i] = W'(i + 1);
      exp_q.push_back(W'(i + 1));
    end
    for (int i = 0; i < 8; i++) begin
      check("t1_no_early_valid", {31'd0, out_valid}, 32'd0);
      psum_valid = 1'b1;
      psum_in    = pv[i];
      step();
    end
    psum_valid = 1'b0;
    check("t1_first_valid", {31'd0, out_valid}, 32'd1);
    wait_idle(cyc);
    check("t1_drain_cycles", W'(cyc), 32'd8);
    check("t1_out_valid_after", {31'd0, out_valid}, 32'd0);
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    // 2) three passes of 5 with random gaps -> 15 everywhere
    start_tile(8'd3, 1'b0);
    fill_const(32'd5);
    feed_pass(3);
    feed_pass(3);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'd15);
    feed_pass(3);
    wait_idle(cyc);
    check("t2_drop_err", {31'd0, drop_err}, 32'd0);

    // 3) back-pressure for 3 cycles at read address 2
    start_tile(8'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pv[i] = W'(10 * (i + 1));
      exp_q.push_back(W'(10 * (i + 1)));
    end
    feed_pass(0);
    step();
    step();
    out_ready = 1'b0;
    check("t3_hold_data0", out_data, 32'd30);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t3_hold_data", out_data, 32'd30);
      check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    wait_idle(cyc);
    check("t3_all_delivered", W'(exp_q.size()), 32'd0);

    // 4) overflow corners plus in-range boundary sums, two passes
    start_tile(8'd2, 1'b0);
    pv[0] = 32'h7FFF_FFFF; pv[1] = 32'h8000_0000; pv[2] = 32'h0000_0064; pv[3] = 32'hFFFF_FFFB;
    pv[4] = 32'h0000_0000; pv[5] = 32'h1234_5678; pv[6] = 32'h7FFF_FFF0; pv[7] = 32'h8000_0010;
    feed_pass(1);
    pv[0] = 32'h0000_0001; pv[1] = 32'hFFFF_FFFF; pv[2] = 32'h0000_0017; pv[3] = 32'h0000_0003;
    pv[4] = 32'hFFFF_FFFF; pv[5] = 32'h1111_1111; pv[6] = 32'h0000_000F; pv[7] = 32'hFFFF_FFF0;
`ifdef PSUM_COLLECTOR_SAT_EN
    exp_q.push_back(32'h7FFF_FFFF);
    exp_q.push_back(32'h8000_0000);
`else
    exp_q.push_back(32'h8000_0000);
    exp_q.push_back(32'h7FFF_FFFF);
`endif
    exp_q.push_back(32'h0000_007B);
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    exp_q.push_back(32'h2345_6789);
    exp_q.push_back(32'h7FFF_FFFF);
    exp_q.push_back(32'h8000_0000);
    feed_pass(0);
    wait_idle(cyc);
    check("t4_drop_err", {31'd0, drop_err}, 32'd0);

    // 5a) sample in IDLE is dropped
    psum_valid = 1'b1;
    psum_in    = 32'h0000_0055;
    step();
    psum_valid = 1'b0;
    check("t5_idle_drop", {31'd0, drop_err}, 32'd1);

    // 5b) accepted start clears; num_passes=0 acts as one pass; drops in DRAIN
    start_tile(8'd0, 1'b0);
    check("t5_clear_on_start", {31'd0, drop_err}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      pv[i] = W'(3 * (i + 1));
      exp_q.push_back(W'(3 * (i + 1)));
    end
    feed_pass(0);
    check("t5_np0_single_pass", {31'd0, out_valid}, 32'd1);
    out_ready  = 1'b0;
    psum_valid = 1'b1;
    psum_in    = 32'h0000_0055;
    step();
    step();
    psum_valid = 1'b0;
    out_ready  = 1'b1;
    check("t5_drain_drop", {31'd0, drop_err}, 32'd1);
    wait_idle(cyc);

    // 5c) sample during the start cycle: dropped, and set beats clear
    start_tile(8'd1, 1'b1);
    check("t5_start_cycle_drop", {31'd0, drop_err}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      pv[i] = 32'h100 + W'(i);
      exp_q.push_back(32'h100 + W'(i));
    end
    feed_pass(0);
    wait_idle(cyc);

    // 6) reset in ACCUM at write address 5, then a fresh single-pass tile
    start_tile(8'd2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      psum_valid = 1'b1;
      psum_in    = 32'h0000_1000;
      step();
    end
    psum_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_busy",      {31'd0, busy},      32'd0);
    check("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_drop_err",  {31'd0, drop_err},  32'd0);
    check("t6_rst_state",     {30'd0, state_dbg}, 32'd0);
    step();
    rst = 1'b0;
    step();
    start_tile(8'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pv[i] = W'(7 + i);
      exp_q.push_back(W'(7 + i));
    end
    feed_pass(0);
    wait_idle(cyc);

    step();
    check("final_queue_empty", W'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
Name: psum_collector

Overview:
- Sits at the bottom of a PE column and receives the registered partial-sum stream emitted by the last PE.
- Accumulates DEPTH consecutive partial sums over a run-time number of input-channel tiling passes into a local buffer.
- Then drains the finished sums to the output/requantization stage over a valid/ready handshake.
- The systolic column cannot stall: inbound samples have no backpressure; misplaced samples are dropped and flagged.

Parameters:
- accumulationPar, 32: width of partial sums (two's complement, signed).
- DEPTH, 8: number of output pixels buffered per tile (power of two, >= 2).
- PASS_W, 8: width of the num_passes input.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a tile; honoured only in IDLE.
- num_passes  in  PASS_W  number of accumulation passes; sampled on accepted start.
- psum_in  in  accumulationPar  partial sum from the last PE.
- psum_valid  in  1  psum_in valid this cycle.
- out_data  out  accumulationPar  finished sum at the drain pointer.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  high in ACCUM or DRAIN.
- drop_err  out  1  sticky: a psum_valid sample was discarded.

Behaviour:
- Reset (async, rst=1):
  - State IDLE; wr_addr, rd_addr, pass counter 0.
  - out_valid=0, busy=0, drop_err=0.
  - Buffer contents not reset; out_data is don't-care while out_valid=0.
- IDLE:
  - start=1 latches last_pass = max(num_passes,1)-1, clears counters, moves to ACCUM next cycle. num_passes=0 behaves as 1.
  - psum_valid in IDLE drops the sample and sets drop_err. This includes the start cycle.
- ACCUM:
  - On each psum_valid:
    - pass==0: buf[wr_addr] <= psum_in.
    - pass>0: buf[wr_addr] <= buf[wr_addr] + psum_in.
  - wr_addr increments; on wr_addr==DEPTH-1 it wraps to 0 and the pass counter increments.
  - If that wrap completes pass last_pass, the state moves to DRAIN at the same edge.
  - Gaps (psum_valid=0) are allowed anywhere; counters hold.
- DRAIN:
  - out_valid=1; out_data=buf[rd_addr], read combinationally from the register array.
  - First out_valid is in the cycle after the edge that sampled the final psum; that final write is already visible.
  - Transfer occurs on out_valid & out_ready. rd_addr increments.
  - After DEPTH transfers the state returns to IDLE; out_valid is low in the next cycle.
  - While out_valid & !out_ready, out_data and rd_addr hold stable.
  - psum_valid in DRAIN drops the sample, sets drop_err, and leaves the buffer untouched.
- start while busy=1 is ignored; num_passes is not re-sampled.
- drop_err is cleared by an accepted start. If set and clear occur in the same cycle, set wins.
- Arithmetic: full accumulationPar-bit two's-complement addition; overflow behaviour per optional feature.
- Reset mid-operation aborts the tile immediately; no partial drain.

Optional Feature:
- Macro PSUM_COLLECTOR_SAT_EN.
- Defined: signed saturating accumulation. Positive overflow clamps to 2^(accumulationPar-1)-1; negative overflow clamps to -2^(accumulationPar-1).
- Undefined: addition wraps modulo 2^accumulationPar. No saturation logic is instantiated.

Test Plan:
- num_passes=1, start, psum_in 1..8 on consecutive cycles, out_ready=1 -> out_data 1..8 on 8 consecutive cycles; first out_valid one cycle after the 8th psum; busy low afterwards.
- num_passes=3, three passes each sending value 5 to every address, with random 1-3 cycle psum_valid gaps -> eight outputs of 15; drop_err=0.
- Drain with out_ready=0 for 3 cycles at rd_addr=2 -> out_data holds buf[2] stable and out_valid stays 1; all 8 values delivered exactly once, in order.
- Overflow: pass0 value 0x7FFFFFFF, pass1 value 0x00000001, num_passes=2 -> 0x80000000 without PSUM_COLLECTOR_SAT_EN, 0x7FFFFFFF with it. Repeat with 0x80000000 + 0xFFFFFFFF -> 0x7FFFFFFF wrapped / 0x80000000 saturated.
- psum_valid=1 during DRAIN and in IDLE -> drop_err=1, drained values unchanged; next accepted start clears drop_err; num_passes=0 behaves as a single pass.
- Assert rst during ACCUM at wr_addr=5 -> outputs go low asynchronously; a subsequent start/1-pass tile produces correct fresh results with no stale accumulation.
